ps_gearbox: RTL
===============

# ps_gearbox

Parametrised, handshaked parallel/serial gearbox for the 8-bit AES datapath. One shared shift register is either loaded with a word and unloaded lane by lane (P2S), or filled lane by lane and presented as a word (S2P). Both sides use valid/ready flow control, so the AHB-side word logic and the byte-serial AES core can stall each other without losing data. Lane order is configurable.

## Interface
Parameters:
- LANE_W, 8, serial lane width in bits
- LANES, 4, lanes per word; must be ≥2; WORD_W = LANE_W*LANES
- MSB_FIRST, 1, 1: lane [WORD_W-1 -: LANE_W] is first out / first in; 0: lane [LANE_W-1:0] is first

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous and active-high
- mode  in  1  0 = P2S, 1 = S2P; sampled only in IDLE and at word boundaries
- p_in_data  in  WORD_W  parallel word to serialise
- p_in_valid  in  1  p_in_data valid
- p_in_ready  out  1  gearbox accepts p_in_data this cycle
- s_out_data  out  LANE_W  serial lane out
- s_out_valid  out  1  s_out_data valid
- s_out_ready  in  1  downstream accepts lane
- s_out_last  out  1  current s_out lane is the word's final lane
- s_in_data  in  LANE_W  serial lane in
- s_in_valid  in  1  s_in_data valid
- s_in_ready  out  1  gearbox accepts s_in_data this cycle
- p_out_data  out  WORD_W  assembled word
- p_out_valid  out  1  p_out_data valid
- p_out_ready  in  1  downstream accepts word
- busy  out  1  state ≠ IDLE

## Operation
- Transfer occurs on a side when valid && ready are both high at posedge clk.
- States: IDLE, UNLOAD (P2S), FILL (S2P), HOLD (S2P word complete).
- IDLE: mode=0 → p_in_ready=1; on p_in transfer load register, cnt=0 → UNLOAD. mode=1 → FILL (one cycle, no transfer).
- UNLOAD: s_out_valid=1; s_out_data = first-order lane of register; on transfer shift register by LANE_W toward the output end, cnt++. s_out_last = (cnt==LANES-1).
- Last-lane transfer: p_in_ready=1 combinationally in that cycle iff mode==0; p_in transfer in the same cycle loads the new word, cnt=0, remain UNLOAD (no bubble). Otherwise → IDLE.
- FILL: s_in_ready=1; on transfer shift s_in_data in at the last-order end, cnt++; on the LANES-th lane → HOLD.
- HOLD: p_out_valid=1, s_in_ready=0, p_out_data = register. On p_out transfer: cnt=0; mode==1 → FILL, else → IDLE.
- Outputs of the inactive direction are held at 0 (valid, ready, last, data).
- mode changes mid-word are ignored until the next word boundary.
- p_out_data and s_out_data are registered-path values (no input-to-data combinational path); only p_in_ready in UNLOAD depends combinationally on s_out_ready and mode.

## Timing
- Reset: state=IDLE, cnt=0, register=0; all outputs 0 except p_in_ready = !mode (combinational from IDLE).
- rst mid-word: partial word discarded, no s_out_last and no p_out_valid emitted afterwards for it.
- P2S: first lane valid the cycle after p_in transfer; LANES cycles per word with s_out_ready held high; back-to-back words with no gap.
- S2P: p_out_valid the cycle after the LANES-th s_in transfer; minimum LANES+1 cycles per word (HOLD cycle is a mandatory bubble on s_in).
- Stalls: s_out_ready=0 holds s_out_data/last stable; p_out_ready=0 holds p_out_data stable indefinitely.
- cnt width $clog2(LANES); wraps only via explicit clear.

## Structure
- Package ps_gearbox_pkg: state enum typedef (IDLE, UNLOAD, FILL, HOLD), MODE_P2S/MODE_S2P constants.
- Single module, no sub-modules; lane select and shift direction derived from MSB_FIRST via generate.

## Test plan
- P2S, MSB_FIRST=1, s_out_ready=1: load 0x00112233 → lanes 0x00,0x11,0x22,0x33 on 4 consecutive cycles, s_out_last only on 0x33.
- P2S back-to-back: 0xA0B0C0D0 then 0x01020304 offered continuously → 8 lanes on 8 consecutive cycles, p_in_ready high on each last-lane cycle.
- S2P, MSB_FIRST=0: lanes 0x44,0x55,0x66,0x77 → p_out_data=0x77665544, p_out_valid one cycle after 4th lane; hold p_out_ready=0 for 5 cycles → data stable, s_in_ready=0.
- Random s_out_ready/s_in_valid backpressure, 100 words each direction → scoreboard matches, no drop/dup.
- mode toggled mid-word (P2S, after lane 2) → word completes as P2S, then IDLE, then FILL.
- rst asserted after 2 S2P lanes → next 4 lanes 0x01..0x04 yield exactly 0x01020304 (MSB_FIRST=1).

Source files
------------

// File: rtl/ps_gearbox_pkg.sv
// Shared types for the parallel/serial gearbox: FSM state encoding and mode values.
// Imported by the gearbox top.
package ps_gearbox_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNLOAD = 2'd1,
    FILL   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic MODE_P2S = 1'b0;
  localparam logic MODE_S2P = 1'b1;

endpackage

// File: rtl/ps_gearbox_if.sv
// Handshake bundle between the gearbox and its word-side / lane-side neighbours.
// slave = gearbox view, master = surrounding logic view.
interface ps_gearbox_if #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4
) ();

  localparam int WORD_W = LANE_W * LANES;

  logic              mode;
  logic [WORD_W-1:0] p_in_data;
  logic              p_in_valid;
  logic              p_in_ready;
  logic [LANE_W-1:0] s_out_data;
  logic              s_out_valid;
  logic              s_out_ready;
  logic              s_out_last;
  logic [LANE_W-1:0] s_in_data;
  logic              s_in_valid;
  logic              s_in_ready;
  logic [WORD_W-1:0] p_out_data;
  logic              p_out_valid;
  logic              p_out_ready;
  logic              busy;

  modport slave (
    input  mode,
    input  p_in_data, p_in_valid, output p_in_ready,
    output s_out_data, s_out_valid, s_out_last, input s_out_ready,
    input  s_in_data, s_in_valid, output s_in_ready,
    output p_out_data, p_out_valid, input p_out_ready,
    output busy
  );

  modport master (
    output mode,
    output p_in_data, p_in_valid, input p_in_ready,
    input  s_out_data, s_out_valid, s_out_last, output s_out_ready,
    output s_in_data, s_in_valid, input s_in_ready,
    input  p_out_data, p_out_valid, output p_out_ready,
    input  busy
  );

endinterface

// File: rtl/ps_gearbox.sv
// Handshaked P2S/S2P gearbox sharing one shift register; word->lanes or lanes->word.
// P2S: first lane one cycle after load, back-to-back words; S2P: word one cycle after last lane.
module ps_gearbox
  import ps_gearbox_pkg::*;
#(
  parameter int LANE_W    = 8,
  parameter int LANES     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  ps_gearbox_if.slave  bus
);

  localparam int WORD_W = LANE_W * LANES;
  localparam int CNT_W  = $clog2(LANES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   sr_q, sr_d;

  logic [LANE_W-1:0]   head_lane;
  logic [WORD_W-1:0]   sr_shift_out;
  logic [WORD_W-1:0]   sr_shift_in;
  logic                last_lane;
  logic                p_in_rdy;
  logic                p_in_fire;
  logic                s_out_fire;
  logic                s_in_fire;
  logic                p_out_fire;

  // Lane order decides which end is read/written and which way the register moves.
  if (MSB_FIRST) begin : g_msb_first
    assign head_lane    = sr_q[WORD_W-1 -: LANE_W];
    assign sr_shift_out = {sr_q[WORD_W-LANE_W-1:0], {LANE_W{1'b0}}};
    assign sr_shift_in  = {sr_q[WORD_W-LANE_W-1:0], bus.s_in_data};
  end else begin : g_lsb_first
    assign head_lane    = sr_q[LANE_W-1:0];
    assign sr_shift_out = {{LANE_W{1'b0}}, sr_q[WORD_W-1:LANE_W]};
    assign sr_shift_in  = {bus.s_in_data, sr_q[WORD_W-1:LANE_W]};
  end

  assign last_lane  = (cnt_q == CNT_LAST);
  assign p_in_fire  = bus.p_in_valid && p_in_rdy;
  assign s_out_fire = (state_q == UNLOAD) && bus.s_out_ready;
  assign s_in_fire  = (state_q == FILL) && bus.s_in_valid;
  assign p_out_fire = (state_q == HOLD) && bus.p_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        if (bus.mode == MODE_S2P) begin
          state_d = FILL;
          cnt_d   = '0;
        end else if (p_in_fire) begin
          sr_d    = bus.p_in_data;
          cnt_d   = '0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (s_out_fire) begin
          if (!last_lane) begin
            sr_d  = sr_shift_out;
            cnt_d = cnt_q + CNT_W'(1);
          end else if (p_in_fire) begin
            // Next word overlaps the final lane so the lane stream has no bubble.
            sr_d  = bus.p_in_data;
            cnt_d = '0;
          end else begin
            sr_d    = sr_shift_out;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      FILL: begin
        if (s_in_fire) begin
          sr_d = sr_shift_in;
          if (last_lane) begin
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (p_out_fire) begin
          cnt_d   = '0;
          state_d = (bus.mode == MODE_S2P) ? FILL : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Data outputs come only from state/register; p_in_ready is the one combinational path.
  always_comb begin
    p_in_rdy        = 1'b0;
    bus.s_out_valid = 1'b0;
    bus.s_out_data  = '0;
    bus.s_out_last  = 1'b0;
    bus.s_in_ready  = 1'b0;
    bus.p_out_valid = 1'b0;
    bus.p_out_data  = '0;
    case (state_q)
      IDLE: begin
        p_in_rdy = (bus.mode == MODE_P2S);
      end
      UNLOAD: begin
        bus.s_out_valid = 1'b1;
        bus.s_out_data  = head_lane;
        bus.s_out_last  = last_lane;
        p_in_rdy        = last_lane && bus.s_out_ready && (bus.mode == MODE_P2S);
      end
      FILL: begin
        bus.s_in_ready = 1'b1;
      end
      HOLD: begin
        bus.p_out_valid = 1'b1;
        bus.p_out_data  = sr_q;
      end
      default: begin
        p_in_rdy = 1'b0;
      end
    endcase
  end

  assign bus.p_in_ready = p_in_rdy;
  assign bus.busy       = (state_q != IDLE);

endmodule
